serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_if.sv | 31 +++
 rtl/full_adder_df.sv | 13 +
 rtl/serial_adder_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  // Controller phases: waiting for work, shifting bits, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand width used when the instantiating level does not override it.
  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Start/ready operand bus and result bus of the serial adder controller.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester side: issues operands, observes status and results.
  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, ovf
  );

  // Adder side: consumes operands, produces status and results.
  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, ovf
  );

endinterface : serial_adder_if

// File: rtl/full_adder_df.sv
// Dataflow one-bit full adder cell, time-shared by the serial controller.
module full_adder_df (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule : full_adder_df

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks a WIDTH-bit operand pair,
// LSB first, one bit per clock, then reports sum, carry-out and overflow.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic             fa_s;
  logic             fa_co;

  full_adder_df u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  // Next-state: load on accepted start, shift-and-add in RUN, hold otherwise.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_sh_d           = a_sh_q >> 1;
        b_sh_d           = b_sh_q >> 1;
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        carry_d          = fa_co;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB on this final bit.
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status is decoded from state only; results come straight from registers.
  assign bus.ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random scoreboard bench for serial_adder_ctrl at WIDTH 1, 8, 32.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_start = 1'b0;
  logic [31:0] tb_a = 32'd0;
  logic [31:0] tb_b = 32'd0;
  logic        tb_cin = 1'b0;
  int          sel = 8;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  serial_adder_if #(.WIDTH(1))  if1  ();
  serial_adder_if #(.WIDTH(8))  if8  ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  assign if1.start  = tb_start & (sel == 1);
  assign if1.a      = tb_a[0:0];
  assign if1.b      = tb_b[0:0];
  assign if1.cin    = tb_cin;
  assign if8.start  = tb_start & (sel == 8);
  assign if8.a      = tb_a[7:0];
  assign if8.b      = tb_b[7:0];
  assign if8.cin    = tb_cin;
  assign if32.start = tb_start & (sel == 32);
  assign if32.a     = tb_a;
  assign if32.b     = tb_b;
  assign if32.cin   = tb_cin;

  serial_adder_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  always #5 clk = ~clk;

  logic        o_ready, o_busy, o_done, o_cout, o_ovf;
  logic [31:0] o_sum;

  // Route the selected instance's outputs to one observation point.
  always_comb begin
    case (sel)
      1: begin
        o_ready = if1.ready; o_busy = if1.busy; o_done = if1.done;
        o_sum = {31'd0, if1.sum}; o_cout = if1.cout; o_ovf = if1.ovf;
      end
      8: begin
        o_ready = if8.ready; o_busy = if8.busy; o_done = if8.done;
        o_sum = {24'd0, if8.sum}; o_cout = if8.cout; o_ovf = if8.ovf;
      end
      default: begin
        o_ready = if32.ready; o_busy = if32.busy; o_done = if32.done;
        o_sum = if32.sum; o_cout = if32.cout; o_ovf = if32.ovf;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (width %0d)", tag, obs, exp, sel);
  endtask

  // Reference: plain integer addition, sign rule from operand/result MSBs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
    exp_t        e;
    logic [32:0] full;
    logic [31:0] mask;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full   = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, cin};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic cin);
    tb_a     = a;
    tb_b     = b;
    tb_cin   = cin;
    tb_start = 1'b1;
    sb.push_back(model(sel, a, b, cin));
    @(posedge clk);
    #1 tb_start = 1'b0;
  endtask

  task automatic await_done(input bit mess);
    int   lat  = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (!seen && lat < sel + 4) begin
      @(negedge clk);
      lat++;
      if (o_done) begin
        seen     = 1'b1;
        tb_start = 1'b0;
      end else if (mess) begin
        tb_start = 1'b1;
        tb_a     = $urandom;
        tb_b     = $urandom;
        tb_cin   = 1'($urandom);
      end
    end
    tb_start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", 32'(lat), 32'(sel + 1));
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e        = sb.pop_front();
      last_exp = e;
      chk("sum",  o_sum, e.sum);
      chk("cout", {31'd0, o_cout}, {31'd0, e.cout});
      chk("ovf",  {31'd0, o_ovf},  {31'd0, e.ovf});
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    chk("done_width", {31'd0, o_done}, 32'd0);
    chk("ready_idle", {31'd0, o_ready}, 32'd1);
    chk("sum_hold", o_sum, last_exp.sum);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic cin, input bit mess);
    wait_ready();
    launch(a, b, cin);
    await_done(mess);
    finish_op();
  endtask

  initial begin
    int dcount;

    // Reset state
    sel = 8;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_busy",  {31'd0, o_busy},  32'd0);
    chk("rst_done",  {31'd0, o_done},  32'd0);
    chk("rst_sum",   o_sum, 32'd0);
    chk("rst_cout",  {31'd0, o_cout},  32'd0);
    chk("rst_ovf",   {31'd0, o_ovf},   32'd0);

    // Directed WIDTH=8 cases
    op(32'h0F, 32'h01, 1'b0, 1'b0);
    op(32'hFF, 32'h01, 1'b0, 1'b0);
    op(32'h7F, 32'h01, 1'b0, 1'b0);

    // Reset abort in the 4th RUN cycle
    wait_ready();
    launch(32'hAA, 32'h55, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort_busy_before", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("abort_ready", {31'd0, o_ready}, 32'd1);
    chk("abort_busy",  {31'd0, o_busy},  32'd0);
    chk("abort_sum",   o_sum, 32'd0);
    chk("abort_ovf",   {31'd0, o_ovf},   32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_done) dcount++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dcount), 32'd0);

    op(32'h00, 32'h00, 1'b1, 1'b0);
    op(32'h80, 32'h80, 1'b0, 1'b0);

    // start held and operands scrambled during RUN
    op(32'h3C, 32'h5A, 1'b1, 1'b1);

    // Back-to-back start in the DONE cycle
    wait_ready();
    launch(32'h12, 32'h34, 1'b0);
    await_done(1'b0);
    launch(32'hC8, 32'h64, 1'b1);
    await_done(1'b0);
    finish_op();

    // WIDTH=1 exhaustive
    sel = 1;
    for (int i = 0; i < 8; i++) begin
      op({31'd0, i[2]}, {31'd0, i[1]}, i[0], 1'b0);
    end

    // Random WIDTH=8 and WIDTH=32
    sel = 8;
    for (int i = 0; i < 1000; i++) op($urandom, $urandom, 1'($urandom), 1'b0);
    sel = 32;
    for (int i = 0; i < 1000; i++) op($urandom, $urandom, 1'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
